// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the pipeline control unit: instruction
// codes, register ids, status codes and the control FSM state type.
package y86_pkg;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // True for the statuses that must freeze the pipeline.
  function automatic logic is_exc_stat(input logic [2:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the control unit (slave).
// There is no valid/ready handshake on this bundle: every signal is a
// per-cycle level. Datapath status is sampled combinationally each cycle and
// the control outputs apply to the pipe registers at the next rising edge.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32) ();
  import y86_pkg::*;

  // Datapath status into the control unit
  logic [63:0]      predPC;
  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [3:0]       M_icode;
  logic             M_Cnd;
  logic [63:0]      M_valA;
  logic [2:0]       m_stat;
  logic [3:0]       W_icode;
  logic [63:0]      W_valM;
  logic [2:0]       W_stat;

  // Control unit outputs back to the datapath
  logic [63:0]      f_pc;
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             halted;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] bub_cnt;
  logic [CNT_W-1:0] misp_cnt;
  state_t           dbg_state;

  modport master (
    output predPC, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, M_Cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
    input  f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           halted, cyc_cnt, bub_cnt, misp_cnt, dbg_state
  );

  modport slave (
    input  predPC, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, M_Cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
    output f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           halted, cyc_cnt, bub_cnt, misp_cnt, dbg_state
  );

endinterface

// File: rtl/hazard_detect.sv
// Pure combinational hazard terms for the 5-stage pipeline:
// load-use, ret in flight, mispredicted branch, and exception status.
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       lu,
  output logic       rt,
  output logic       misp,
  output logic       exc
);

  // Evaluate all four hazard conditions from the current stage contents.
  always_comb begin
    lu   = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
           (E_dstM != RNONE) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt   = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    misp = (E_icode == IJXX) && !e_Cnd;
    exc  = is_exc_stat(m_stat) || is_exc_stat(W_stat);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: owns the predicted-PC register, selects the fetch
// PC, turns hazard terms into stall/bubble controls, freezes the pipeline
// once a non-AOK status reaches W, and keeps saturating perf counters.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             lu, rt, misp, exc;
  state_t           state_q, state_d;
  logic [63:0]      pred_pc_q;
  logic [CNT_W-1:0] cyc_q, bub_q, misp_q;
  logic             f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;
  logic             halted_c;

  hazard_detect u_hazard_detect (
    .D_icode (bus.D_icode),
    .d_srcA  (bus.d_srcA),
    .d_srcB  (bus.d_srcB),
    .E_icode (bus.E_icode),
    .E_dstM  (bus.E_dstM),
    .e_Cnd   (bus.e_Cnd),
    .M_icode (bus.M_icode),
    .m_stat  (bus.m_stat),
    .W_stat  (bus.W_stat),
    .lu      (lu),
    .rt      (rt),
    .misp    (misp),
    .exc     (exc)
  );

  // Fetch PC: a not-taken branch reaching M wins, then a ret return address
  // in W, otherwise the prediction held in the F register.
  always_comb begin
    bus.f_pc = pred_pc_q;
    if ((bus.M_icode == IJXX) && !bus.M_Cnd) begin
      bus.f_pc = bus.M_valA;
    end else if (bus.W_icode == IRET) begin
      bus.f_pc = bus.W_valM;
    end
  end

  // FSM next state and pipe-register controls. A load-use stalls D rather
  // than bubbling it even when a ret is also in flight.
  always_comb begin
    state_d  = state_q;
    f_stall  = lu | rt;
    d_stall  = lu;
    d_bubble = misp | (~lu & rt);
    e_bubble = misp | lu;
    m_bubble = exc;
    w_stall  = (bus.W_stat != SAOK);
    halted_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.W_stat != SAOK) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b1;
        w_stall  = 1'b1;
        halted_c = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state register; HALTED is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Predicted-PC register follows the predictor unless F is held or halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= RESET_PC;
    end else if (!f_stall && (state_q == ST_RUN)) begin
      pred_pc_q <= bus.predPC;
    end
  end

  // Saturating perf counters, advancing only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      bub_q  <= '0;
      misp_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (cyc_q != CNT_MAX) cyc_q <= cyc_q + CNT_ONE;
      if ((d_bubble || e_bubble) && (bub_q != CNT_MAX)) bub_q <= bub_q + CNT_ONE;
      if (misp && (misp_q != CNT_MAX)) misp_q <= misp_q + CNT_ONE;
    end
  end

  assign bus.F_stall   = f_stall;
  assign bus.D_stall   = d_stall;
  assign bus.D_bubble  = d_bubble;
  assign bus.E_bubble  = e_bubble;
  assign bus.M_bubble  = m_bubble;
  assign bus.W_stall   = w_stall;
  assign bus.halted    = halted_c;
  assign bus.cyc_cnt   = cyc_q;
  assign bus.bub_cnt   = bub_q;
  assign bus.misp_cnt  = misp_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random
// pipeline contents with occasional resets, checked by a scoreboard against
// a behavioural model of the control rules.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int W = 64 + 7 + 3 * CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.RESET_PC(64'h0), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [63:0] m_pred;
  bit          m_halt;
  int          m_cyc, m_bub, m_misp;
  int          halt_age;

  function automatic bit bad_stat(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic terms(output bit lu, output bit rt, output bit misp, output bit exc);
    lu   = (bus.E_icode == 4'd5 || bus.E_icode == 4'd11) && bus.E_dstM != 4'd15 &&
           (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    rt   = (bus.D_icode == 4'd9) || (bus.E_icode == 4'd9) || (bus.M_icode == 4'd9);
    misp = (bus.E_icode == 4'd7) && !bus.e_Cnd;
    exc  = bad_stat(bus.m_stat) || bad_stat(bus.W_stat);
  endtask

  task automatic model_reset();
    m_pred = 64'h0;
    m_halt = 1'b0;
    m_cyc  = 0;
    m_bub  = 0;
    m_misp = 0;
    halt_age = 0;
  endtask

  // State change at a rising edge, using the inputs held through that edge.
  task automatic model_edge();
    bit lu, rt, misp, exc;
    bit dbub, ebub;
    terms(lu, rt, misp, exc);
    if (m_halt) begin
      halt_age++;
    end else begin
      dbub = misp || (rt && !lu);
      ebub = misp || lu;
      if (!(lu || rt)) m_pred = bus.predPC;
      m_cyc = sat(m_cyc + 1);
      if (dbub || ebub) m_bub = sat(m_bub + 1);
      if (misp) m_misp = sat(m_misp + 1);
      if (bus.W_stat != 3'd1) m_halt = 1'b1;
    end
  endtask

  // Expected outputs for the current cycle, pushed to the scoreboard.
  task automatic push_exp();
    bit lu, rt, misp, exc;
    logic [63:0] pc;
    logic [6:0] ctl;
    terms(lu, rt, misp, exc);
    if (bus.M_icode == 4'd7 && !bus.M_Cnd) pc = bus.M_valA;
    else if (bus.W_icode == 4'd9)          pc = bus.W_valM;
    else                                   pc = m_pred;
    if (m_halt)
      ctl = 7'b1100111;
    else
      ctl = {lu || rt, lu, misp || (rt && !lu), misp || lu, exc,
             bus.W_stat != 3'd1, 1'b0};
    exp_q.push_back({pc, ctl, CW'(m_cyc), CW'(m_bub), CW'(m_misp)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
  endtask

  task automatic step();
    push_exp();
    tick();
  endtask

  task automatic idle_inputs();
    bus.D_icode = 4'd1;
    bus.d_srcA  = 4'd15;
    bus.d_srcB  = 4'd15;
    bus.E_icode = 4'd1;
    bus.E_dstM  = 4'd15;
    bus.e_Cnd   = 1'b1;
    bus.M_icode = 4'd1;
    bus.M_Cnd   = 1'b1;
    bus.M_valA  = 64'h0;
    bus.m_stat  = 3'd1;
    bus.W_icode = 4'd1;
    bus.W_valM  = 64'h0;
    bus.W_stat  = 3'd1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
  endtask

  function automatic logic [2:0] rand_stat(input int odds);
    logic [2:0] s;
    s = 3'd1;
    if ($urandom_range(0, odds) == 0) begin
      case ($urandom_range(0, 3))
        0: s = 3'd0;
        1: s = 3'd2;
        2: s = 3'd3;
        default: s = 3'd4;
      endcase
    end
    return s;
  endfunction

  task automatic random_inputs();
    bus.predPC  = {$urandom, $urandom};
    bus.D_icode = 4'($urandom_range(0, 11));
    bus.d_srcA  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
    bus.d_srcB  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
    bus.E_icode = 4'($urandom_range(0, 11));
    bus.E_dstM  = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
    bus.e_Cnd   = 1'($urandom_range(0, 1));
    bus.M_icode = 4'($urandom_range(0, 11));
    bus.M_Cnd   = 1'($urandom_range(0, 1));
    bus.M_valA  = {$urandom, $urandom};
    bus.m_stat  = rand_stat(30);
    bus.W_icode = 4'($urandom_range(0, 11));
    bus.W_valM  = {$urandom, $urandom};
    bus.W_stat  = rand_stat(60);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.f_pc,
           {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble,
            bus.W_stall, bus.halted},
           bus.cyc_cnt, bus.bub_cnt, bus.misp_cnt};
      n_chk++;
      if (a[W-1 -: 64] !== e[W-1 -: 64]) begin
        n_err++;
        $display("FAIL f_pc @%0t: got %h expected %h", $time, a[W-1 -: 64], e[W-1 -: 64]);
      end
      n_chk++;
      if (a[3*CW+6 -: 7] !== e[3*CW+6 -: 7]) begin
        n_err++;
        $display("FAIL ctrl(Fst,Dst,Dbub,Ebub,Mbub,Wst,halt) @%0t: got %b expected %b",
                 $time, a[3*CW+6 -: 7], e[3*CW+6 -: 7]);
      end
      n_chk++;
      if (a[3*CW-1:0] !== e[3*CW-1:0]) begin
        n_err++;
        $display("FAIL counters(cyc,bub,misp) @%0t: got %h expected %h",
                 $time, a[3*CW-1:0], e[3*CW-1:0]);
      end
    end
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    bus.predPC = 64'h0A;
    assert_reset();
    tick();

    // Reset held one checked cycle, then release: f_pc 0 then 0x0A.
    step();
    rst_n = 1'b1;
    step();
    step();

    // Load-use: mrmovq in E writing r3, decode reads r3.
    bus.E_icode = 4'd5; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
    bus.predPC = 64'h1234;
    step();
    idle_inputs();
    step();

    // Mispredicted jXX in E, then the same branch in M redirects fetch.
    bus.E_icode = 4'd7; bus.e_Cnd = 1'b0;
    step();
    idle_inputs();
    bus.M_icode = 4'd7; bus.M_Cnd = 1'b0; bus.M_valA = 64'h40;
    step();
    idle_inputs();

    // ret travelling D -> E -> M -> W.
    bus.D_icode = 4'd9; step();
    bus.D_icode = 4'd1; bus.E_icode = 4'd9; step();
    bus.E_icode = 4'd1; bus.M_icode = 4'd9; step();
    bus.M_icode = 4'd1; bus.W_icode = 4'd9; bus.W_valM = 64'h100; step();
    idle_inputs();

    // Run long enough to saturate the 4-bit cycle counter.
    for (int i = 0; i < 14; i++) begin
      bus.predPC = 64'(i * 8 + 64'h200);
      step();
    end

    // Exception: bad status in M, then in W, then frozen while halted.
    bus.m_stat = 3'd3; step();
    bus.m_stat = 3'd1; bus.W_stat = 3'd3; step();
    bus.W_stat = 3'd1;
    for (int i = 0; i < 4; i++) begin
      bus.predPC = 64'(i + 64'h900);
      step();
    end

    // Reset pulse while halted with saturated counters.
    assert_reset();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Random pipeline contents with resets after halts and at random.
    for (int i = 0; i < 2000; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ((m_halt && halt_age >= 3) || $urandom_range(0, 249) == 0) begin
        assert_reset();
      end
      random_inputs();
      step();
    end

    // Let the monitor drain the last expectation.
    repeat (2) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
